// File: rtl/tnn_pkg.sv
// Shared definitions for the TNN layer compare scheduler: FSM states, operand width
// and the index-width helper.
package tnn_pkg;

  localparam int TNN_OP_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tnn_operand_snapshot.sv
// Layer operand store: captures every neuron's (a, b, c) triple on load and
// presents the triple addressed by sel.
module tnn_operand_snapshot
  import tnn_pkg::*;
#(
  parameter int N_NEURONS = 6,
  parameter int W         = TNN_OP_W,
  parameter int IW        = idx_w(N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [N_NEURONS*W-1:0] a_vec,
  input  logic [N_NEURONS*W-1:0] b_vec,
  input  logic [N_NEURONS*W-1:0] c_vec,
  input  logic [IW-1:0]          sel,
  output logic [W-1:0]           sel_a,
  output logic [W-1:0]           sel_b,
  output logic [W-1:0]           sel_c
);

  logic [W-1:0] a_q [N_NEURONS];
  logic [W-1:0] b_q [N_NEURONS];
  logic [W-1:0] c_q [N_NEURONS];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        a_q[k] <= a_vec[k*W +: W];
        b_q[k] <= b_vec[k*W +: W];
        c_q[k] <= c_vec[k*W +: W];
      end
    end
  end

  // Out-of-range selects read zero.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (sel == IW'(k)) begin
        sel_a = a_q[k];
        sel_b = b_q[k];
        sel_c = c_q[k];
      end
    end
  end

endmodule

// File: rtl/tnn_cmp_scheduler.sv
// Issues one neuron's operand triple per cycle to a shared (a+b)>c unit, gathers
// the decisions into res_vec and offers the vector over a valid/ready handshake.
module tnn_cmp_scheduler
  import tnn_pkg::*;
#(
  parameter int N_NEURONS = 6,
  parameter int W         = TNN_OP_W,
  parameter int CMP_LAT   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N_NEURONS*W-1:0] a_vec,
  input  logic [N_NEURONS*W-1:0] b_vec,
  input  logic [N_NEURONS*W-1:0] c_vec,
  output logic                   busy,
  output logic [W-1:0]           cmp_a,
  output logic [W-1:0]           cmp_b,
  output logic [W-1:0]           cmp_c,
  output logic                   cmp_vld,
  input  logic                   cmp_out,
  output logic [N_NEURONS-1:0]   res_vec,
  output logic                   res_valid,
  input  logic                   res_ready
);

  localparam int            IW   = idx_w(N_NEURONS);
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  sched_state_t  state;
  logic [IW-1:0] idx;
  logic [IW-1:0] next_sel;
  logic          accept;
  logic          issue_last;
  logic [W-1:0]  snap_a, snap_b, snap_c;
  logic          vld_p1;
  logic [IW-1:0] ptr_p1;
  logic          cap_en;
  logic [IW-1:0] cap_ptr;

  assign accept     = (state == IDLE) && start;
  assign issue_last = (state == ISSUE) && (idx == LAST);
  assign next_sel   = idx + IW'(1);
  assign busy       = (state != IDLE);
  assign res_valid  = (state == HOLD);

  // The snapshot is addressed one slot ahead so the next triple is ready to register.
  tnn_operand_snapshot #(
    .N_NEURONS(N_NEURONS),
    .W        (W),
    .IW       (IW)
  ) u_snapshot (
    .clk   (clk),
    .load  (accept),
    .a_vec (a_vec),
    .b_vec (b_vec),
    .c_vec (c_vec),
    .sel   (next_sel),
    .sel_a (snap_a),
    .sel_b (snap_b),
    .sel_c (snap_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            idx   <= '0;
          end
        end
        ISSUE: begin
          if (idx == LAST) state <= (CMP_LAT == 1) ? DRAIN : HOLD;
          else             idx   <= next_sel;
        end
        DRAIN:   state <= HOLD;
        HOLD:    if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Slot 0 comes straight from the inputs because the snapshot fills on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld <= 1'b0;
      cmp_a   <= '0;
      cmp_b   <= '0;
      cmp_c   <= '0;
    end else if (accept) begin
      cmp_vld <= 1'b1;
      cmp_a   <= a_vec[W-1:0];
      cmp_b   <= b_vec[W-1:0];
      cmp_c   <= c_vec[W-1:0];
    end else if (issue_last) begin
      cmp_vld <= 1'b0;
    end else if (state == ISSUE) begin
      cmp_a   <= snap_a;
      cmp_b   <= snap_b;
      cmp_c   <= snap_c;
    end
  end

  // Stage p1: issue slot delayed by one cycle for a registered comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= (state == ISSUE);
  end

  always_ff @(posedge clk) begin
    ptr_p1 <= idx;
  end

  always_comb begin
    cap_en  = (state == ISSUE);
    cap_ptr = idx;
    if (CMP_LAT == 1) begin
      cap_en  = vld_p1;
      cap_ptr = ptr_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      res_vec          <= '0;
    else if (accept) res_vec          <= '0;
    else if (cap_en) res_vec[cap_ptr] <= cmp_out;
  end

endmodule

// File: tb/tb_tnn_cmp_scheduler.sv
// Bench for tnn_cmp_scheduler: three instances (N=6 combinational compare, N=6
// registered compare, N=1) checked against a per-neuron (a+b)>c reference.
module tb_tnn_cmp_scheduler;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: N=6, CMP_LAT=0
  logic        start0 = 0, ready0 = 0;
  logic [17:0] a0 = '0, b0 = '0, c0 = '0;
  logic        busy0, vld0, rv0, cout0;
  logic [2:0]  ca0, cb0, cc0;
  logic [5:0]  res0;
  assign cout0 = (int'(ca0) + int'(cb0)) > int'(cc0);

  // Instance 1: N=6, CMP_LAT=1
  logic        start1 = 0, ready1 = 0;
  logic [17:0] a1 = '0, b1 = '0, c1 = '0;
  logic        busy1, vld1, rv1;
  logic        cout1 = 1'b0;
  logic [2:0]  ca1, cb1, cc1;
  logic [5:0]  res1;
  always @(posedge clk) cout1 <= (int'(ca1) + int'(cb1)) > int'(cc1);

  // Instance 2: N=1, CMP_LAT=0
  logic        start2 = 0, ready2 = 0;
  logic [2:0]  a2 = '0, b2 = '0, c2 = '0;
  logic        busy2, vld2, rv2, cout2;
  logic [2:0]  ca2, cb2, cc2;
  logic [0:0]  res2;
  assign cout2 = (int'(ca2) + int'(cb2)) > int'(cc2);

  tnn_cmp_scheduler #(.N_NEURONS(6), .W(3), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_vec(a0), .b_vec(b0), .c_vec(c0),
    .busy(busy0), .cmp_a(ca0), .cmp_b(cb0), .cmp_c(cc0), .cmp_vld(vld0),
    .cmp_out(cout0), .res_vec(res0), .res_valid(rv0), .res_ready(ready0));

  tnn_cmp_scheduler #(.N_NEURONS(6), .W(3), .CMP_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_vec(a1), .b_vec(b1), .c_vec(c1),
    .busy(busy1), .cmp_a(ca1), .cmp_b(cb1), .cmp_c(cc1), .cmp_vld(vld1),
    .cmp_out(cout1), .res_vec(res1), .res_valid(rv1), .res_ready(ready1));

  tnn_cmp_scheduler #(.N_NEURONS(1), .W(3), .CMP_LAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_vec(a2), .b_vec(b2), .c_vec(c2),
    .busy(busy2), .cmp_a(ca2), .cmp_b(cb2), .cmp_c(cc2), .cmp_vld(vld2),
    .cmp_out(cout2), .res_vec(res2), .res_valid(rv2), .res_ready(ready2));

  // Reference: decision for neuron k is (a_k + b_k) > c_k on plain integers.
  function automatic logic [5:0] ref6(input logic [17:0] a, input logic [17:0] b,
                                      input logic [17:0] c);
    logic [5:0] r;
    for (int k = 0; k < 6; k++)
      r[k] = (int'(a[k*3 +: 3]) + int'(b[k*3 +: 3])) > int'(c[k*3 +: 3]);
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (vld0 !== 1'b0) begin failures++; $display("FAIL reset_cmp_vld: got %b want 0", vld0); end
    checks++; if ({ca0, cb0, cc0} !== 9'd0) begin failures++; $display("FAIL reset_cmp_ops: got %h want 0", {ca0, cb0, cc0}); end
    checks++; if (res0 !== 6'd0) begin failures++; $display("FAIL reset_res_vec: got %b want 0", res0); end
    checks++; if ({rv0, rv1, rv2, busy1, busy2} !== 5'd0) begin failures++; $display("FAIL reset_valid_busy: got %b want 0", {rv0, rv1, rv2, busy1, busy2}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lat0_basic();
    logic [5:0] exp;
    int lat, nvld;
    logic seq_ok;
    for (int k = 0; k < 6; k++) begin
      a0[k*3 +: 3] = 3'(k); b0[k*3 +: 3] = 3'd1; c0[k*3 +: 3] = 3'd3;
    end
    exp = ref6(a0, b0, c0);
    lat = 0; nvld = 0; seq_ok = 1'b1;
    @(negedge clk); start0 = 1; @(posedge clk); #1 start0 = 0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      if (vld0) begin
        if (ca0 !== 3'(cyc - 1)) seq_ok = 1'b0;
        nvld++;
      end
      if (rv0) lat = cyc;
    end
    checks++; if (lat != 7) begin failures++; $display("FAIL lat0_latency: got %0d want 7", lat); end
    checks++; if (nvld != 6) begin failures++; $display("FAIL lat0_issue_cycles: got %0d want 6", nvld); end
    checks++; if (seq_ok !== 1'b1) begin failures++; $display("FAIL lat0_cmp_a_sequence: got bad order want 0..5"); end
    checks++; if (res0 !== exp) begin failures++; $display("FAIL lat0_res_vec: got %b want %b", res0, exp); end
    ready0 = 1; @(posedge clk); #1 ready0 = 0;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL lat0_idle_after_accept: got busy=%b want 0", busy0); end
  endtask

  task automatic test_lat1_basic();
    logic [5:0] exp;
    int lat, ndrain;
    for (int k = 0; k < 6; k++) begin
      a1[k*3 +: 3] = 3'(k); b1[k*3 +: 3] = 3'd1; c1[k*3 +: 3] = 3'd3;
    end
    exp = ref6(a1, b1, c1);
    lat = 0; ndrain = 0;
    @(negedge clk); start1 = 1; @(posedge clk); #1 start1 = 0;
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      if (busy1 && !vld1 && !rv1) ndrain++;
      if (rv1) lat = cyc;
    end
    checks++; if (lat != 8) begin failures++; $display("FAIL lat1_latency: got %0d want 8", lat); end
    checks++; if (ndrain != 1) begin failures++; $display("FAIL lat1_drain_cycles: got %0d want 1", ndrain); end
    checks++; if (res1 !== exp) begin failures++; $display("FAIL lat1_res_vec: got %b want %b", res1, exp); end
    ready1 = 1; @(posedge clk); #1 ready1 = 0;
  endtask

  task automatic test_hold_stall();
    logic [5:0] exp;
    logic stable, issued, got;
    a0 = 18'($urandom); b0 = 18'($urandom); c0 = 18'($urandom);
    exp = ref6(a0, b0, c0);
    stable = 1'b1; issued = 1'b0; got = 1'b0;
    @(negedge clk); start0 = 1; @(posedge clk); #1 start0 = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      got = rv0;
    end
    checks++; if (!got) begin failures++; $display("FAIL stall_wait_valid: got timeout want res_valid"); end
    for (int h = 0; h < 10; h++) begin
      if (h == 4) start0 = 1;
      if (h == 5) start0 = 0;
      @(negedge clk);
      if (res0 !== exp || busy0 !== 1'b1 || rv0 !== 1'b1) stable = 1'b0;
      if (vld0) issued = 1'b1;
    end
    checks++; if (!stable) begin failures++; $display("FAIL stall_hold_stable: got res=%b busy=%b valid=%b want res=%b busy=1 valid=1", res0, busy0, rv0, exp); end
    checks++; if (issued) begin failures++; $display("FAIL stall_start_ignored: got cmp_vld=1 want 0"); end
    ready0 = 1; start0 = 1;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL stall_start_with_ready: got busy=%b want 0", busy0); end
    ready0 = 0; start0 = 0;
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    logic [5:0] exp;
    logic got;
    a0 = 18'($urandom); b0 = 18'($urandom); c0 = 18'($urandom);
    exp = ref6(a0, b0, c0);
    got = 1'b0;
    @(negedge clk); start0 = 1; @(posedge clk); #1 start0 = 0;
    @(negedge clk); a0 = '1; b0 = 18'($urandom); c0 = '0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      got = rv0;
    end
    checks++; if (!got || res0 !== exp) begin failures++; $display("FAIL snapshot_res_vec: got %b (valid=%b) want %b", res0, got, exp); end
    ready0 = 1; @(posedge clk); #1 ready0 = 0;
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    logic got;
    a0 = '1; b0 = 18'($urandom); c0 = '0;
    @(negedge clk); start0 = 1; @(posedge clk); #1 start0 = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (vld0 !== 1'b1 || res0 === 6'd0) begin failures++; $display("FAIL midreset_pre: got vld=%b res=%b want vld=1 res nonzero", vld0, res0); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy0, vld0, rv0} !== 3'b000) begin failures++; $display("FAIL midreset_ctrl: got %b want 000", {busy0, vld0, rv0}); end
    checks++; if (res0 !== 6'd0 || {ca0, cb0, cc0} !== 9'd0) begin failures++; $display("FAIL midreset_data: got res=%b ops=%h want 0", res0, {ca0, cb0, cc0}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rv0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL midreset_no_valid: got valid=%b busy=%b want 0", rv0, busy0); end
    a0 = 18'($urandom); b0 = 18'($urandom); c0 = 18'($urandom);
    exp = ref6(a0, b0, c0);
    got = 1'b0;
    start0 = 1; @(posedge clk); #1 start0 = 0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      @(negedge clk);
      got = rv0;
    end
    checks++; if (!got || res0 !== exp) begin failures++; $display("FAIL midreset_recover: got %b (valid=%b) want %b", res0, got, exp); end
    ready0 = 1; @(posedge clk); #1 ready0 = 0;
  endtask

  task automatic test_n1();
    logic exp;
    int lat, nvld, nres, last, prev;
    logic gap_ok, res_ok;
    a2 = 3'd7; b2 = 3'd7; c2 = 3'd0;
    lat = 0; nvld = 0;
    @(negedge clk); start2 = 1; @(posedge clk); #1 start2 = 0;
    for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
      @(negedge clk);
      if (vld2) nvld++;
      if (rv2) lat = cyc;
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL n1_latency: got %0d want 2", lat); end
    checks++; if (nvld != 1) begin failures++; $display("FAIL n1_issue_cycles: got %0d want 1", nvld); end
    checks++; if (res2 !== 1'b1) begin failures++; $display("FAIL n1_res_vec: got %b want 1", res2); end
    ready2 = 1; @(posedge clk); #1 ready2 = 0;
    @(negedge clk);
    a2 = 3'($urandom); b2 = 3'($urandom); c2 = 3'($urandom);
    exp = (int'(a2) + int'(b2)) > int'(c2);
    nres = 0; prev = -1; gap_ok = 1'b1; res_ok = 1'b1;
    ready2 = 1; start2 = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rv2) begin
        if (prev >= 0 && i - prev != 3) gap_ok = 1'b0;
        if (res2 !== exp) res_ok = 1'b0;
        prev = i;
        nres++;
      end
    end
    start2 = 0; ready2 = 0;
    last = prev;
    checks++; if (nres != 10) begin failures++; $display("FAIL n1_b2b_count: got %0d want 10", nres); end
    checks++; if (!gap_ok) begin failures++; $display("FAIL n1_b2b_period: got irregular (last at %0d) want 3", last); end
    checks++; if (!res_ok) begin failures++; $display("FAIL n1_b2b_res: got %b want %b", res2, exp); end
    @(negedge clk);
  endtask

  task automatic test_random_lat1();
    logic [5:0] exp;
    int lat, d;
    logic stable;
    for (int n = 0; n < 8; n++) begin
      a1 = 18'($urandom); b1 = 18'($urandom); c1 = 18'($urandom);
      exp = ref6(a1, b1, c1);
      d = int'($urandom_range(0, 3));
      lat = 0; stable = 1'b1;
      @(negedge clk); start1 = 1; @(posedge clk); #1 start1 = 0;
      a1 = 18'($urandom); b1 = 18'($urandom); c1 = 18'($urandom);
      for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
        @(negedge clk);
        if (rv1) lat = cyc;
      end
      for (int h = 0; h < d; h++) begin
        @(negedge clk);
        if (res1 !== exp || rv1 !== 1'b1) stable = 1'b0;
      end
      checks++; if (lat != 8) begin failures++; $display("FAIL rand_lat1_latency[%0d]: got %0d want 8", n, lat); end
      checks++; if (res1 !== exp || !stable) begin failures++; $display("FAIL rand_lat1_res[%0d]: got %b stable=%b want %b", n, res1, stable, exp); end
      ready1 = 1; @(posedge clk); #1 ready1 = 0;
    end
  endtask

  initial begin
    test_reset();
    test_lat0_basic();
    test_lat1_basic();
    test_hold_stall();
    test_snapshot();
    test_reset_mid();
    test_n1();
    test_random_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
